// File: rtl/separator.sv
// Splits one valid/ready stream into two independent streams through one-entry slots.
// Latency 1 cycle; input stalls whenever either slot cannot take a new word this cycle.
module separator #(
  parameter int    WIDTH0 = 32,
  parameter int    WIDTH1 = 32,
  parameter string BURST  = "yes"
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iValid_AM,
  output logic                     oReady_AM,
  input  logic [WIDTH1+WIDTH0-1:0] iData_AM,
  output logic                     oValid_BM0,
  input  logic                     iReady_BM0,
  output logic [WIDTH0-1:0]        oData_BM0,
  output logic                     oValid_BM1,
  input  logic                     iReady_BM1,
  output logic [WIDTH1-1:0]        oData_BM1
);

  localparam bit BurstEn = (BURST == "yes");

  logic              full0_q, full0_d;
  logic              full1_q, full1_d;
  logic [WIDTH0-1:0] data0_q, data0_d;
  logic [WIDTH1-1:0] data1_q, data1_d;

  logic can_load0, can_load1;
  logic drain0, drain1;
  logic accept;

  assign drain0 = full0_q && iReady_BM0;
  assign drain1 = full1_q && iReady_BM1;

  // In burst mode a draining slot frees up in the same edge, so it may reload.
  assign can_load0 = BurstEn ? (!full0_q || iReady_BM0) : !full0_q;
  assign can_load1 = BurstEn ? (!full1_q || iReady_BM1) : !full1_q;

  assign oReady_AM = can_load0 && can_load1 && !iRST;
  assign accept    = iValid_AM && oReady_AM;

  always_comb begin
    full0_d = full0_q;
    full1_d = full1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    if (accept) begin
      full0_d = 1'b1;
      full1_d = 1'b1;
      data0_d = iData_AM[WIDTH1+WIDTH0-1:WIDTH1];
      data1_d = iData_AM[WIDTH1-1:0];
    end else begin
      if (drain0) full0_d = 1'b0;
      if (drain1) full1_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      full0_q <= full0_d;
      full1_q <= full1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  assign oValid_BM0 = full0_q;
  assign oValid_BM1 = full1_q;
  assign oData_BM0  = data0_q;
  assign oData_BM1  = data1_q;

endmodule

// File: tb/tb_separator.sv
// Bench for separator: directed cases plus random scoreboard runs on burst and non-burst instances.
module tb_separator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // burst instance
  logic        y_rst = 1'b1, y_val = 1'b0, y_rdy0 = 1'b0, y_rdy1 = 1'b0;
  logic [15:0] y_dat = '0;
  logic        y_ordy, y_vld0, y_vld1;
  logic [7:0]  y_out0, y_out1;
  // non-burst instance
  logic        n_rst = 1'b1, n_val = 1'b0, n_rdy0 = 1'b0, n_rdy1 = 1'b0;
  logic [15:0] n_dat = '0;
  logic        n_ordy, n_vld0, n_vld1;
  logic [7:0]  n_out0, n_out1;

  separator #(.WIDTH0(8), .WIDTH1(8), .BURST("yes")) u_y (
    .iCLK(clk), .iRST(y_rst), .iValid_AM(y_val), .oReady_AM(y_ordy), .iData_AM(y_dat),
    .oValid_BM0(y_vld0), .iReady_BM0(y_rdy0), .oData_BM0(y_out0),
    .oValid_BM1(y_vld1), .iReady_BM1(y_rdy1), .oData_BM1(y_out1)
  );

  separator #(.WIDTH0(8), .WIDTH1(8), .BURST("no")) u_n (
    .iCLK(clk), .iRST(n_rst), .iValid_AM(n_val), .oReady_AM(n_ordy), .iData_AM(n_dat),
    .oValid_BM0(n_vld0), .iReady_BM0(n_rdy0), .oData_BM0(n_out0),
    .oValid_BM1(n_vld1), .iReady_BM1(n_rdy1), .oData_BM1(n_out1)
  );

  logic [7:0] y_q0[$], y_q1[$], n_q0[$], n_q1[$];
  int y_acc = 0, y_pop0 = 0, y_pop1 = 0;
  int n_acc = 0;

  // Scoreboards: handshakes sampled mid-cycle, pops before pushes.
  always @(negedge clk) begin
    if (y_rst) begin
      y_q0.delete();
      y_q1.delete();
    end else begin
      if (y_vld0 && y_rdy0) begin
        if (y_q0.size() == 0) chk("y_b0_extra", y_q0.size(), 1);
        else begin chk("y_b0", {24'h0, y_out0}, {24'h0, y_q0.pop_front()}); y_pop0++; end
      end
      if (y_vld1 && y_rdy1) begin
        if (y_q1.size() == 0) chk("y_b1_extra", y_q1.size(), 1);
        else begin chk("y_b1", {24'h0, y_out1}, {24'h0, y_q1.pop_front()}); y_pop1++; end
      end
      if (y_val && y_ordy) begin
        y_q0.push_back(y_dat[15:8]);
        y_q1.push_back(y_dat[7:0]);
        y_acc++;
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      n_q0.delete();
      n_q1.delete();
    end else begin
      if (n_vld0 && n_rdy0) begin
        if (n_q0.size() == 0) chk("n_b0_extra", n_q0.size(), 1);
        else chk("n_b0", {24'h0, n_out0}, {24'h0, n_q0.pop_front()});
      end
      if (n_vld1 && n_rdy1) begin
        if (n_q1.size() == 0) chk("n_b1_extra", n_q1.size(), 1);
        else chk("n_b1", {24'h0, n_out1}, {24'h0, n_q1.pop_front()});
      end
      if (n_val && n_ordy) begin
        n_q0.push_back(n_dat[15:8]);
        n_q1.push_back(n_dat[7:0]);
        n_acc++;
      end
    end
  end

  initial begin
    int cyc;
    int base_y, base_n;

    // reset state
    tick(); tick();
    chk("rst_vld0", y_vld0, 0);
    chk("rst_vld1", y_vld1, 0);
    chk("rst_dat0", y_out0, 0);
    chk("rst_dat1", y_out1, 0);
    chk("rst_ordy", y_ordy, 0);
    y_rst = 1'b0;
    #1;
    chk("post_rst_ordy", y_ordy, 1);

    // single word split
    y_val = 1'b1; y_dat = 16'hA55A; y_rdy0 = 1'b1; y_rdy1 = 1'b1;
    tick();
    y_val = 1'b0;
    chk("a55a_vld0", y_vld0, 1);
    chk("a55a_dat0", y_out0, 8'hA5);
    chk("a55a_vld1", y_vld1, 1);
    chk("a55a_dat1", y_out1, 8'h5A);
    tick(); tick();

    // back-to-back burst
    for (int i = 0; i < 16; i++) begin
      y_val = 1'b1;
      y_dat = 16'(i * 16'h0101);
      #1;
      chk("burst_ordy", y_ordy, 1);
      if (i > 0) begin
        chk("burst_vld0", y_vld0, 1);
        chk("burst_vld1", y_vld1, 1);
      end
      tick();
    end
    y_val = 1'b0;
    tick(); tick();
    chk("burst_cnt0", y_pop0, 17);
    chk("burst_cnt1", y_pop1, 17);

    // branch 1 stalled, branch 0 keeps draining
    y_rdy0 = 1'b1; y_rdy1 = 1'b0;
    y_val = 1'b1; y_dat = 16'h1234;
    tick();
    y_dat = 16'h5678;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_ordy", y_ordy, 0);
      chk("stall_vld1", y_vld1, 1);
      chk("stall_dat1", y_out1, 8'h34);
      chk("stall_vld0", y_vld0, (k == 0) ? 1 : 0);
      tick();
    end
    y_rdy1 = 1'b1;
    #1;
    chk("unstall_ordy", y_ordy, 1);
    tick();
    y_val = 1'b0;
    tick(); tick();

    // reset while both slots are full and stalled
    y_rdy0 = 1'b0; y_rdy1 = 1'b0;
    y_val = 1'b1; y_dat = 16'hBEEF;
    tick();
    y_dat = 16'hDEAD;
    chk("full_vld0", y_vld0, 1);
    chk("full_vld1", y_vld1, 1);
    y_rst = 1'b1;
    #1;
    chk("rst_mid_ordy", y_ordy, 0);
    tick();
    y_rst = 1'b0; y_val = 1'b0;
    #1;
    chk("flush_vld0", y_vld0, 0);
    chk("flush_vld1", y_vld1, 0);
    chk("flush_dat0", y_out0, 0);
    chk("flush_dat1", y_out1, 0);
    chk("flush_ordy", y_ordy, 1);
    y_rdy0 = 1'b1; y_rdy1 = 1'b1;
    tick(); tick(); tick();

    // non-burst: ready alternates under continuous input
    n_rst = 1'b0; n_rdy0 = 1'b1; n_rdy1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n_val = 1'b1;
      n_dat = 16'h3000 + 16'(k);
      #1;
      chk("n_alt_ordy", n_ordy, (k % 2 == 0) ? 1 : 0);
      tick();
    end
    n_val = 1'b0;
    tick(); tick();
    chk("n_alt_cnt", n_acc, 5);

    // random traffic on both instances
    base_y = y_acc;
    base_n = n_acc;
    cyc = 0;
    while ((y_acc - base_y < 1000 || n_acc - base_n < 1000) && cyc < 20000) begin
      y_val = 1'($urandom_range(0, 1)); y_rdy0 = 1'($urandom_range(0, 1)); y_rdy1 = 1'($urandom_range(0, 1));
      y_dat = 16'($urandom);
      n_val = 1'($urandom_range(0, 1)); n_rdy0 = 1'($urandom_range(0, 1)); n_rdy1 = 1'($urandom_range(0, 1));
      n_dat = 16'($urandom);
      tick();
      cyc++;
    end
    y_val = 1'b0; n_val = 1'b0;
    y_rdy0 = 1'b1; y_rdy1 = 1'b1; n_rdy0 = 1'b1; n_rdy1 = 1'b1;
    tick(); tick(); tick(); tick();
    chk("y_rand_words", (y_acc - base_y >= 1000) ? 1 : 0, 1);
    chk("n_rand_words", (n_acc - base_n >= 1000) ? 1 : 0, 1);
    chk("y_left0", y_q0.size(), 0);
    chk("y_left1", y_q1.size(), 0);
    chk("n_left0", n_q0.size(), 0);
    chk("n_left1", n_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
